main_fsm: RTL
=============

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port op, input, 7 bits: opcode field of the instruction register.
REQ-004 SHALL have port funct3, input, 3 bits: instruction funct3 field.
REQ-005 SHALL have port funct7b5, input, 1 bit: instruction bit 30.
REQ-006 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory handshake; the access completes in the cycle where it is 1.
REQ-008 SHALL have outputs PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, 1 bit each: datapath enables and select.
REQ-009 SHALL have outputs ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, 2 bits each: datapath muxes.
REQ-010 SHALL have output ALUControl, 3 bits: ALU operation.
REQ-011 SHALL have output illegal_instr, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-012 SHALL have output state, 4 bits: current state, for debug.

Function
REQ-013 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10; codes 11-15 SHALL go to FETCH.
REQ-014 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=mem_ready; hold until mem_ready=1, then go to DECODE.
REQ-015 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next state by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1101111 -> JAL, 1100011 -> BEQ, otherwise FETCH with illegal_instr=1 for this cycle.
REQ-016 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; op=0000011 -> MEMREAD, else MEMWRITE.
REQ-017 MEMREAD: AdrSrc=1, ResultSrc=00; hold until mem_ready=1, then go to MEMWB.
REQ-018 MEMWB: ResultSrc=01, RegWrite=1; go to FETCH.
REQ-019 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 while in state; hold until mem_ready=1, then go to FETCH.
REQ-020 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI: same except ALUSrcB=01; both go to ALUWB.
REQ-021 ALUWB: ResultSrc=00, RegWrite=1; go to FETCH.
REQ-022 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; go to ALUWB.
REQ-023 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero; go to FETCH.
REQ-024 Any output not listed for a state SHALL be 0.
REQ-025 ImmSrc SHALL be a combinational decode of op: I-type/load 00, store 01, beq 10, jal 11, other 00.
REQ-026 ALUControl SHALL be ALU-decoder(ALUOp, funct3, funct7b5, op[5]): ALUOp 00 -> add 000, 01 -> sub 001, 10 -> funct3 decode with R-type sub (op[5]&funct7b5) -> 001.
REQ-027 Write enables SHALL be asserted at most once per handshake; mem_ready=0 in FETCH/MEMREAD/MEMWRITE SHALL stall indefinitely with outputs held.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=FETCH and force PCWrite, IRWrite, MemWrite, RegWrite and illegal_instr to 0 while it is low.
REQ-029 Deassertion SHALL start fetch in the next rising edge; reset mid-instruction SHALL abandon the instruction without any write.

Structure
REQ-030 State encodings, opcode constants and ALUOp codes SHALL live in a shared package, riscv_ctrl_pkg.
REQ-031 ALUControl SHALL come from one instantiated sub-module, Alu_Decoder; the FSM drives its ALUOp.

Verification
REQ-032 lw (op=0000011), mem_ready=1 always -> states 0,1,2,3,4,0; RegWrite=1 only in state 4, ResultSrc=01.
REQ-033 sw (op=0100011), mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then FETCH.
REQ-034 R-type sub (op=0110011, funct3=000, funct7b5=1) -> EXECR with ALUControl=001, then ALUWB with RegWrite=1.
REQ-035 beq with zero=1, then beq with zero=0 -> PCWrite=1, then PCWrite=0 in BEQ.
REQ-036 op=1111111 -> DECODE pulses illegal_instr=1, then FETCH; no write enables asserted.
REQ-037 rst_n low asynchronously during MEMWRITE -> state=0 and MemWrite=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared state, opcode and ALU encodings for the multicycle controller
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE: imm_src = 2'b01;
      OP_BEQ:   imm_src = 2'b10;
      OP_JAL:   imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/main_fsm_alu_decoder.sv
// rtl/main_fsm_alu_decoder.sv - maps ALUOp and instruction fields to the ALU operation
module Alu_Decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type uses funct7b5 for sub; in I-type it is immediate data.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multicycle RISC-V main control FSM with ALU decode
module main_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_instr,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_write, ir_write, mem_write, reg_write, illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BEQ:            state_d = S_BEQ;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        alu_op   = ALUOP_SUB;
        pc_write = zero;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are gated by reset so a low rst_n blocks writes before any edge.
  assign PCWrite       = pc_write  & rst_n;
  assign IRWrite       = ir_write  & rst_n;
  assign MemWrite      = mem_write & rst_n;
  assign RegWrite      = reg_write & rst_n;
  assign illegal_instr = illegal   & rst_n;
  assign ImmSrc        = imm_src(op);
  assign state         = state_q;

  Alu_Decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule
